clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; parameters and ports are as listed below.
REQ-002 Parameter NUM_CH, default 4: number of independent divider channels, range 1..16.
REQ-003 Parameter CNT_W, default 8: width of each divide ratio.
REQ-004 Port Clk, input, 1 bit: single system clock; all state SHALL update on its rising edge.
REQ-005 Port Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port Enable, input, NUM_CH bits: per-channel run enable.
REQ-007 Port Div, input, NUM_CH x CNT_W bits: per-channel divide ratio D.
REQ-008 Port Sync, input, 1 bit: one-cycle request to restart all enabled channels phase-aligned.
REQ-009 Port ClkOut, output, NUM_CH bits: divided clock, registered.
REQ-010 Port Tick, output, NUM_CH bits: one-cycle pulse marking the first cycle of each period, registered.
REQ-011 Port Active, output, NUM_CH bits: channel running.

Function
REQ-012 Each channel SHALL hold a counter cnt (CNT_W bits) and a shadow ratio Ds, both loaded from Div.
REQ-013 Effective ratio De SHALL be max(Ds,1); Div=0 SHALL behave exactly as Div=1.
REQ-014 States per channel: IDLE and RUN. IDLE->RUN when Enable=1 at a rising edge; RUN->IDLE when Enable=0 at a rising edge.
REQ-015 On the IDLE->RUN edge, Ds SHALL load Div and cnt SHALL load 0; Tick=1 and ClkOut=1 SHALL be visible in the following cycle.
REQ-016 In RUN, cnt SHALL increment each cycle and wrap to 0 after De-1; at each wrap, Ds SHALL reload from Div (glitch-free ratio change only at period boundary).
REQ-017 ClkOut SHALL be 1 while cnt < ceil(De/2) and 0 otherwise, giving high time ceil(De/2) and low time floor(De/2).
REQ-018 Tick SHALL be 1 exactly in the cycles where cnt=0 in RUN; with De=1, Tick SHALL be held 1 and ClkOut held 1.
REQ-019 Active SHALL be 1 in RUN and 0 in IDLE.
REQ-020 A Div change mid-period SHALL NOT affect the current period's length or duty.
REQ-021 On RUN->IDLE, ClkOut, Tick and Active SHALL be 0 from the next cycle; cnt SHALL be cleared.
REQ-022 Sync=1 at an edge SHALL, for every channel in RUN (or entering RUN at that edge), load cnt=0 and Ds=Div, so all such channels show Tick=1 in the same following cycle.
REQ-023 Sync SHALL have no effect on channels with Enable=0 at that edge.
REQ-024 Sync coinciding with a natural wrap SHALL produce a single Tick, with no extra or missing pulse.
REQ-025 Channels SHALL be fully independent except for the shared Sync.

Reset
REQ-026 Rst_n=0 SHALL asynchronously force all channels to IDLE with cnt=0, Ds=0, ClkOut=0, Tick=0, Active=0.
REQ-027 After Rst_n deasserts, a channel SHALL enter RUN only at an edge where Enable=1, per REQ-015.
REQ-028 Reset asserted mid-period SHALL discard the period; no partial Tick SHALL follow release.

Structure
REQ-029 Package clk_div_pkg SHALL hold the default CNT_W, MAX_CH=16, and the channel state enum (IDLE, RUN).
REQ-030 A single sub-module clk_div_ch SHALL implement one channel; clk_div_gen SHALL instantiate it NUM_CH times via generate and fan out Sync.

Verification
REQ-031 Div=4, Enable rising, then held: ClkOut=1100 repeating and Tick=1000 repeating from the cycle after enable.
REQ-032 Div=3 -> ClkOut=110 and Tick=100; Div=1 and Div=0 -> ClkOut and Tick constantly 1.
REQ-033 Div changed from 4 to 6 at cnt=1: the current period completes as 4 cycles, then ClkOut=111000.
REQ-034 Channel 0 Div=4 and channel 1 Div=6 running, Sync pulsed: both Tick in the same next cycle; a disabled channel 2 stays 0.
REQ-035 Enable dropped at cnt=2 with Div=8: all outputs 0 next cycle; re-enable restarts with Tick after one cycle.
REQ-036 Rst_n asserted asynchronously mid-period (between edges): outputs 0 immediately; after release, no Tick until Enable is sampled high.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider:
//   CNT_W_DEF  - default width of a per-channel divide ratio
//   MAX_CH     - largest supported channel count (NUM_CH range is 1..MAX_CH)
//   ch_state_e - per-channel run state (IDLE, RUN)
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int MAX_CH    = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divider channel. While enabled, counts 0..De-1 (De = max(Ds,1)) and
// produces a registered divided clock (high for ceil(De/2) cycles, low for
// floor(De/2)) and a registered one-cycle Tick on the first cycle of each
// period. The shadow ratio Ds only reloads at a period boundary, on entry to
// RUN, or on Sync, so a ratio change never distorts the period in flight.
//
// Ports:
//   Clk     in   system clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   Enable  in   run enable for this channel
//   Div     in   divide ratio D (0 behaves as 1)
//   Sync    in   restart request (only acts while enabled)
//   ClkOut  out  divided clock, registered
//   Tick    out  period-start pulse, registered
//   Active  out  channel is in RUN
// -----------------------------------------------------------------------------
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Enable,
   input  logic [CNT_W-1:0] Div,
   input  logic             Sync,
   output logic             ClkOut,
   output logic             Tick,
   output logic             Active
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ds_q, ds_d;
   logic             clkout_q, clkout_d;
   logic             tick_q, tick_d;

   logic [CNT_W-1:0] de_q;     // effective ratio of the current period
   logic [CNT_W-1:0] de_d;     // effective ratio of the period after this edge
   logic [CNT_W:0]   half_d;   // ceil(de_d/2), one bit wider to hold the carry
   logic             run_d;

   always_comb begin
      // NOTE: every combinational output is given a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      ds_d     = ds_q;

      de_q     = (ds_q == '0) ? CNT_W'(1) : ds_q;

      case (state_q)
         IDLE: begin
            if (Enable) begin
               state_d = RUN;
               cnt_d   = '0;
               ds_d    = Div;
            end
         end
         RUN: begin
            if (!Enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (Sync || (cnt_q >= de_q - 1'b1)) begin
               // Sync landing on a natural wrap gives the same result, so only
               // one Tick is produced.
               cnt_d = '0;
               ds_d  = Div;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered, so they are derived from the next-state values
      // and appear in the cycle that the new cnt/Ds describe.
      de_d     = (ds_d == '0) ? CNT_W'(1) : ds_d;
      half_d   = ({1'b0, de_d} + (CNT_W+1)'(1)) >> 1;
      run_d    = (state_d == RUN);
      tick_d   = run_d && (cnt_d == '0);
      clkout_d = run_d && ({1'b0, cnt_d} < half_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ds_q     <= '0;
         clkout_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ds_q     <= ds_d;
         clkout_q <= clkout_d;
         tick_q   <= tick_d;
      end
   end

   assign ClkOut = clkout_q;
   assign Tick   = tick_q;
   assign Active = (state_q == RUN);

endmodule : clk_div_ch

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
// NUM_CH independent clock dividers sharing one clock, reset and Sync.
// NUM_CH must lie in 1..MAX_CH.
//
// Ports:
//   Clk     in   system clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   Enable  in   [NUM_CH]          per-channel run enable
//   Div     in   [NUM_CH*CNT_W]    per-channel ratio, channel i at
//                                  Div[i*CNT_W +: CNT_W]
//   Sync    in   restart all enabled channels phase-aligned
//   ClkOut  out  [NUM_CH]          divided clocks, registered
//   Tick    out  [NUM_CH]          period-start pulses, registered
//   Active  out  [NUM_CH]          channel running
// -----------------------------------------------------------------------------
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [NUM_CH-1:0]       Enable,
   input  logic [NUM_CH*CNT_W-1:0] Div,
   input  logic                    Sync,
   output logic [NUM_CH-1:0]       ClkOut,
   output logic [NUM_CH-1:0]       Tick,
   output logic [NUM_CH-1:0]       Active
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .Clk    (Clk),
         .Rst_n  (Rst_n),
         .Enable (Enable[i]),
         .Div    (Div[i*CNT_W +: CNT_W]),
         .Sync   (Sync),
         .ClkOut (ClkOut[i]),
         .Tick   (Tick[i]),
         .Active (Active[i])
      );
   end

endmodule : clk_div_gen

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
// Self-checking bench for clk_div_gen. The reference model describes each
// channel as a queue of (ClkOut, Tick) pairs for the period in progress: a
// period of length L = max(Div,1) is ceil(L/2) high cycles then floor(L/2)
// low cycles with Tick on the first. A new period is queued when the channel
// starts, when Sync hits it, or when the previous period is used up.
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic                    Clk;
   logic                    Rst_n;
   logic [NUM_CH-1:0]       Enable;
   logic [NUM_CH*CNT_W-1:0] Div;
   logic                    Sync;
   logic [NUM_CH-1:0]       ClkOut;
   logic [NUM_CH-1:0]       Tick;
   logic [NUM_CH-1:0]       Active;

   clk_div_gen #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Enable (Enable),
      .Div    (Div),
      .Sync   (Sync),
      .ClkOut (ClkOut),
      .Tick   (Tick),
      .Active (Active)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit                running [NUM_CH];
   bit [1:0]          per_q   [NUM_CH][$];   // {clkout, tick} per cycle
   logic [NUM_CH-1:0] exp_clk, exp_tick, exp_act;

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         running[c] = 1'b0;
         per_q[c].delete();
      end
      exp_clk  = '0;
      exp_tick = '0;
      exp_act  = '0;
   endtask

   task automatic start_period(input int c);
      int len;
      len = int'(Div[c*CNT_W +: CNT_W]);
      if (len == 0) len = 1;
      per_q[c].delete();
      for (int i = 0; i < len; i++)
         per_q[c].push_back({(i < (len + 1) / 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
   endtask

   // Applies the inputs seen at a rising edge; result is what the DUT should
   // show during the following cycle.
   task automatic model_edge();
      bit [1:0] e;
      if (!Rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!Enable[c]) begin
            running[c] = 1'b0;
            per_q[c].delete();
            exp_clk[c]  = 1'b0;
            exp_tick[c] = 1'b0;
            exp_act[c]  = 1'b0;
         end else begin
            if (!running[c] || Sync || per_q[c].size() == 0) start_period(c);
            running[c]  = 1'b1;
            e           = per_q[c].pop_front();
            exp_clk[c]  = e[1];
            exp_tick[c] = e[0];
            exp_act[c]  = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check("clkout", 32'(ClkOut), 32'(exp_clk));
      check("tick",   32'(Tick),   32'(exp_tick));
      check("active", 32'(Active), 32'(exp_act));
   endtask

   task automatic set_div(input int c, input int v);
      Div[c*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [3:0] pat4;
   logic [2:0] pat3;

   initial begin
      Rst_n  = 1'b0;
      Enable = '0;
      Div    = '0;
      Sync   = 1'b0;
      model_reset();

      #3;
      check("reset_clkout", 32'(ClkOut), 32'd0);
      check("reset_tick",   32'(Tick),   32'd0);
      check("reset_active", 32'(Active), 32'd0);

      @(negedge Clk);
      Rst_n = 1'b1;
      cycle();

      // Div=4: ClkOut 1100, Tick 1000 from the cycle after enable
      set_div(0, 4);
      Enable[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         pat4 = 4'b1100;
         check("div4_clk", 32'(ClkOut[0]), 32'(pat4[3 - (k % 4)]));
         pat4 = 4'b1000;
         check("div4_tick", 32'(Tick[0]), 32'(pat4[3 - (k % 4)]));
      end
      Enable[0] = 1'b0;
      cycle();

      // Div=3: ClkOut 110, Tick 100
      set_div(1, 3);
      Enable[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         pat3 = 3'b110;
         check("div3_clk", 32'(ClkOut[1]), 32'(pat3[2 - (k % 3)]));
         pat3 = 3'b100;
         check("div3_tick", 32'(Tick[1]), 32'(pat3[2 - (k % 3)]));
      end
      Enable[1] = 1'b0;

      // Div=1 on ch2 and Div=0 on ch3: both constantly high
      set_div(2, 1);
      set_div(3, 0);
      Enable[3:2] = 2'b11;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("div1_div0_clk",  32'(ClkOut[3:2]), 32'd3);
         check("div1_div0_tick", 32'(Tick[3:2]),   32'd3);
      end
      Enable = '0;
      cycle();

      // Div 4 -> 6 while cnt=1: period finishes at 4, then 111000
      set_div(0, 4);
      Enable[0] = 1'b1;
      cycle();
      cycle();
      set_div(0, 6);
      for (int k = 0; k < 14; k++) cycle();
      Enable[0] = 1'b0;
      cycle();

      // Sync with ch0 Div=4, ch1 Div=6 running, ch2 disabled
      set_div(0, 4);
      set_div(1, 6);
      set_div(2, 5);
      Enable = 4'b0011;
      for (int k = 0; k < 3; k++) cycle();
      Sync = 1'b1;
      cycle();
      Sync = 1'b0;
      check("sync_tick_aligned", 32'(Tick[2:0]), 32'b011);
      for (int k = 0; k < 8; k++) cycle();
      Enable = '0;
      cycle();

      // Enable dropped at cnt=2 with Div=8, then re-enabled
      set_div(0, 8);
      Enable[0] = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      Enable[0] = 1'b0;
      cycle();
      check("drop_all_zero", 32'({ClkOut[0], Tick[0], Active[0]}), 32'd0);
      Enable[0] = 1'b1;
      cycle();
      check("reenable_tick", 32'(Tick[0]), 32'd1);
      for (int k = 0; k < 5; k++) cycle();

      // Asynchronous reset between edges, then Enable low before restart
      @(posedge Clk);
      model_edge();
      #2;
      Rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_outputs", 32'({ClkOut, Tick, Active}), 32'd0);
      Enable = '0;
      @(negedge Clk);
      cycle();
      Rst_n = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      check("post_rst_no_tick", 32'(Tick), 32'd0);
      set_div(0, 5);
      Enable[0] = 1'b1;
      cycle();
      check("post_rst_first_tick", 32'(Tick[0]), 32'd1);

      // Randomized phase
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 19) == 0) Enable[c] = ~Enable[c];
            if ($urandom_range(0, 9) == 0)  set_div(c, int'($urandom_range(0, 9)));
         end
         Sync = ($urandom_range(0, 11) == 0);
         cycle();
      end
      Sync = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_clk_div_gen
